// File: rtl/tx_logic_pkg.sv
// tx_logic_pkg: shared NoC sizes and port-index encoding, plus the FSM state type.
`ifndef NOC_DEFINES
`define NOC_DEFINES
`define ADDR_SZ 4
`define PAYLOAD_SIZE 8
`define PORT_N 0
`define PORT_S 1
`define PORT_E 2
`define PORT_W 3
`define PORT_L 4
`endif

package tx_logic_pkg;
    localparam int ADDR_SZ = `ADDR_SZ;
    localparam int HALF = `ADDR_SZ / 2;
    localparam int ITEM_W = `PAYLOAD_SIZE + `ADDR_SZ;
    localparam int NPORT = 5;
    localparam int P_N = `PORT_N;
    localparam int P_S = `PORT_S;
    localparam int P_E = `PORT_E;
    localparam int P_W = `PORT_W;
    localparam int P_L = `PORT_L;
    typedef logic [ITEM_W-1:0] item_t;
    typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/tx_logic_if.sv
// tx_logic_if: source-buffer handshake and the five destination ports of the router.
interface tx_logic_if;
    import tx_logic_pkg::*;
    logic empty, read, busy;
    item_t item_in;
    logic n_full, s_full, e_full, w_full, l_full;
    logic n_write, s_write, e_write, w_write, l_write;
    item_t n_item, s_item, e_item, w_item, l_item;
    logic [15:0] sent_count;
    modport master (
        output empty, item_in, n_full, s_full, e_full, w_full, l_full,
        input  read, busy, sent_count, n_write, s_write, e_write, w_write, l_write,
        input  n_item, s_item, e_item, w_item, l_item
    );
    modport slave (
        input  empty, item_in, n_full, s_full, e_full, w_full, l_full,
        output read, busy, sent_count, n_write, s_write, e_write, w_write, l_write,
        output n_item, s_item, e_item, w_item, l_item
    );
endinterface

// File: rtl/tx_logic_xy_route.sv
// xy_route: dimension-ordered (X first, then Y) route to a one-hot output port.
module xy_route
    import tx_logic_pkg::*;
#(
    parameter logic [HALF-1:0] MY_X = '0,
    parameter logic [HALF-1:0] MY_Y = '0
) (
    input  logic [ADDR_SZ-1:0] addr_i,
    output logic [NPORT-1:0]   port_o
);
    logic [HALF-1:0] dx, dy;
    assign dx = addr_i[ADDR_SZ-1:HALF];
    assign dy = addr_i[HALF-1:0];
    assign port_o = NPORT'(1) << (dx > MY_X ? P_E : dx < MY_X ? P_W :
                                  dy > MY_Y ? P_N : dy < MY_Y ? P_S : P_L);
endmodule

// File: rtl/tx_logic.sv
// tx_logic: single-entry holding stage that pops a FWFT source buffer and pushes
// each item to its XY-routed output port, counting deliveries.
module tx_logic
    import tx_logic_pkg::*;
#(
    parameter logic [HALF-1:0] MY_X = '0,
    parameter logic [HALF-1:0] MY_Y = '0
) (
    input logic     clk,
    input logic     rst,
    tx_logic_if.slave bus
);
    state_t state_q, state_d;
    item_t item_q, item_d;
    logic [15:0] cnt_q, cnt_d;
    logic [NPORT-1:0] route, full, wr;
    logic deliver, rd;

    xy_route #(.MY_X(MY_X), .MY_Y(MY_Y)) u_route (
        .addr_i(item_q[ADDR_SZ-1:0]),
        .port_o(route)
    );

    assign full = {bus.l_full, bus.w_full, bus.e_full, bus.s_full, bus.n_full};

    // read is gated by rst so the source is never popped while reset is held
    always_comb begin
        wr = (state_q == HOLD) ? route & ~full : '0;
        deliver = |wr;
        rd = !rst && !bus.empty && (state_q == IDLE || deliver);
        item_d = rd ? bus.item_in : item_q;
        state_d = rd ? HOLD : deliver ? IDLE : state_q;
        cnt_d = cnt_q + 16'(deliver);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            item_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            item_q <= item_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.read = rd;
    assign {bus.l_write, bus.w_write, bus.e_write, bus.s_write, bus.n_write} = wr;
    assign bus.n_item = item_q;
    assign bus.s_item = item_q;
    assign bus.e_item = item_q;
    assign bus.w_item = item_q;
    assign bus.l_item = item_q;
    assign bus.busy = state_q == HOLD;
    assign bus.sent_count = cnt_q;
endmodule

// File: doc/tx_logic.md
TX_LOGIC -- requirements
Module: tx_logic

Interface
REQ-001 Parameter: MY_X, 0, router X coordinate, width `ADDR_SZ/2.
REQ-002 Parameter: MY_Y, 0, router Y coordinate, width `ADDR_SZ/2.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: empty  input  1  source buffer has no item.
REQ-006 Port: item_in  input  `PAYLOAD_SIZE+`ADDR_SZ  head of source buffer, first-word-fall-through, valid while !empty.
REQ-007 Port: read  output  1  pops source buffer on this clock edge.
REQ-008 Ports: n_full, s_full, e_full, w_full, l_full  input  1 each  destination port cannot accept.
REQ-009 Ports: n_write, s_write, e_write, w_write, l_write  output  1 each  push held item to that port.
REQ-010 Ports: n_item, s_item, e_item, w_item, l_item  output  `PAYLOAD_SIZE+`ADDR_SZ each  all driven from the single holding register.
REQ-011 Port: busy  output  1  holding register occupied.
REQ-012 Port: sent_count  output  16  items delivered since reset, wraps 0xFFFF->0x0000.

Function
REQ-013 Destination address SHALL be item[`ADDR_SZ-1:0]; dest X = upper `ADDR_SZ/2 bits of that field, dest Y = lower `ADDR_SZ/2 bits.
REQ-014 Routing SHALL be XY, from the holding register: dx>MY_X east; dx<MY_X west; dx==MY_X and dy>MY_Y north; dy<MY_Y south; both equal local.
REQ-015 Comparisons SHALL be unsigned.
REQ-016 Two states: IDLE (busy=0), HOLD (busy=1).
REQ-017 Exactly one x_write SHALL be high at a time: in HOLD, on the routed port, when that port's x_full=0; all writes 0 in IDLE.
REQ-018 Deliver = HOLD and the routed write asserted.
REQ-019 read SHALL be combinational: !empty and (IDLE or deliver).
REQ-020 On read, item_in SHALL be captured into the holding register at the same edge; state -> HOLD.
REQ-021 On deliver without read, state -> IDLE; register contents don't-care but SHALL NOT re-deliver.
REQ-022 Deliver and read in the same cycle SHALL be legal; back-to-back throughput one item per cycle.
REQ-023 In HOLD with routed port full, the register, state and all outputs SHALL remain stable (no head-of-line bypass).
REQ-024 Fullness of non-routed ports SHALL NOT affect behaviour.
REQ-025 IDLE to first write latency: one cycle after the read edge.
REQ-026 sent_count SHALL increment by 1 on every deliver edge.
REQ-027 read SHALL never assert when empty=1.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, holding register 0, sent_count 0; read and all x_write low while rst high.
REQ-029 An item held at reset assertion SHALL be discarded; the source-buffer item is not popped.

Structure
REQ-030 `PAYLOAD_SIZE, `ADDR_SZ and the port-index encoding (N=0,S=1,E=2,W=3,L=4) SHALL come from the shared NoC defines file.
REQ-031 The XY route computation SHALL be a sub-module, xy_route (address in, one-hot 5-bit port out), reusable by other routers.

Verification (`ADDR_SZ=4, `PAYLOAD_SIZE=8, MY_X=1, MY_Y=1)
REQ-032 Single item addr 4'b1001 (x=2,y=1), all ports free -> read in cycle 0, e_write=1 in cycle 1 only, e_item=item, sent_count=1.
REQ-033 Stream of 4 items to addrs 0x0,0x5,0x6,0x4 with no stalls -> w, local, north, south writes on 4 consecutive cycles; read high 4 consecutive cycles.
REQ-034 Item to addr 0x7 (north) with n_full=1 for 3 cycles, e_full=1 throughout -> busy=1, n_write=0, read=0 for 3 cycles; n_write on 4th cycle; e_full has no effect.
REQ-035 rst pulse while HOLD with n_full=1 -> busy, writes and read drop asynchronously; after release with empty=0 the next item is read; sent_count=0.
REQ-036 Preload sent_count to 0xFFFF via 65535 deliveries, one more deliver -> sent_count=0x0000.
